branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It replaces the fixed predict-not-taken behaviour of the baseline core.
- IF stage looks it up combinationally with the fetch word address and gets a taken/target prediction in the same cycle.
- ID stage reports each resolved branch, which trains the tables.
- Supports bimodal mode and gshare mode, has a configurable table depth, and keeps branch/mispredict statistics.

Parameters:
ENTRIES, 16, number of BTB and counter-table entries; power of two, minimum 2; IDX = log2(ENTRIES).
HIST_BITS, 4, global history register width; 1 to IDX.
MODE, 0, 0 = bimodal (counter index = pc[IDX-1:0]); 1 = gshare (counter index = pc[IDX-1:0] XOR zero-extended history).
ADDR_W, 30, word-address width; matches the ICACHE_addr width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
stall  input  1  pipeline memory_stall; blocks training while high.
lookup_pc  input  ADDR_W  IF-stage fetch word address.
pred_hit  output  1  BTB entry valid and tag matches lookup_pc.
pred_taken  output  1  predict taken: pred_hit & counter[1].
pred_target  output  ADDR_W  BTB target word address; 0 when pred_hit=0.
pred_ghr  output  HIST_BITS  current global history; pipeline carries it to ID.
upd_valid  input  1  ID stage resolved a conditional branch/jump this cycle.
upd_pc  input  ADDR_W  word address of the resolved branch.
upd_ghr  input  HIST_BITS  pred_ghr value captured when that branch was fetched.
upd_taken  input  1  actual outcome.
upd_target  input  ADDR_W  actual target word address.
upd_mispredict  input  1  the ID stage flushed IF for this branch.
branch_cnt  output  32  applied updates, wraps at 2^32.
mispredict_cnt  output  32  applied updates with upd_mispredict=1, wraps.

Behaviour:
Table contents:
- BTB entry = {valid, tag = pc[ADDR_W-1:IDX], target}, indexed by pc[IDX-1:0] in both modes.
- Counter table holds 2-bit saturating counters; encoding SNT=00, WNT=01, WT=10, ST=11.
- Lookup uses the mode-dependent index with the current GHR.
- Update uses the mode-dependent index with upd_ghr, so lookup and training hit the same entry.

Lookup:
- Purely combinational from lookup_pc and registered state; zero-cycle latency.

Apply condition:
- An update is applied on a rising edge when rst_n=1, upd_valid=1 and stall=0.
- While stall=1 the update is ignored, because ID re-presents the same branch after the stall; each branch is trained exactly once.

Applied update, all on the same edge:
- Counter: +1 if upd_taken, saturating at 11; -1 if not taken, saturating at 00.
- BTB:
  - if upd_taken: write valid=1, tag, target, replacing any aliasing entry;
  - if not taken: BTB unchanged.
- GHR: ghr <= {ghr[HIST_BITS-2:0], upd_taken}. In MODE 0 the GHR is still maintained but not used for indexing.
- branch_cnt +1; mispredict_cnt +1 when upd_mispredict=1.

Same-cycle lookup and update of the same entry: lookup returns the pre-update value; the new value is visible from the next cycle.

Reset (synchronous, rst_n=0 at an edge):
- All BTB valid bits 0; all counters WNT; GHR 0; both statistics counters 0.
- Outputs after the reset edge: pred_hit=0, pred_taken=0, pred_target=0, pred_ghr=0, branch_cnt=0, mispredict_cnt=0.
- Reset takes priority over a simultaneous update; an update presented during reset is discarded.
- Table storage is flops, so clearing completes in one cycle and there is no init FSM.

Decomposition:
Package bp_pkg holds:
- counter encodings SNT/WNT/WT/ST and reset value WNT;
- MODE constants BP_BIMODAL=0, BP_GSHARE=1;
- saturating-counter next-state function.

One sub-module, bp_btb: valid/tag/target storage, combinational tag compare, write port. The top holds the counter table, GHR, index logic and statistics.

Test Plan:
All scenarios use ENTRIES=16, HIST_BITS=4, MODE=0 unless stated.
1. Reset: rst_n=0 one edge, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0, branch_cnt=0, mispredict_cnt=0.
2. Training: two taken updates pc=0x10 target=0x80 -> lookup 0x10 gives hit=1, target=0x80, taken=1 (counter 01->10->11). A third taken update keeps 11. Then one not-taken -> still taken (10); a second not-taken -> taken=0, hit=1.
3. Aliasing: train pc=0x10 taken, then pc=0x20 taken target=0x99 (same index 0) -> lookup 0x10 hit=0; lookup 0x20 hit=1, target=0x99.
4. Stall: upd_valid=1 with stall=1 for 3 cycles -> counters, BTB and branch_cnt unchanged. Deassert stall -> exactly one update applied, branch_cnt=1.
5. Gshare, MODE=1:
   - Outcomes T,N,T,T from reset -> pred_ghr sequence 0001, 0010, 0101, 1011.
   - Update pc=0x3 with upd_ghr=0101 -> only counter index 0x6 changes.
6. Same-cycle collision: lookup and update of pc=0x10 on the same cycle -> lookup shows the old prediction; the next cycle shows the new one. Update with upd_mispredict=1 -> mispredict_cnt increments by 1.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings, mode constants and counter update for the branch predictor
package bp_pkg;

  typedef logic [1:0] cnt_t;

  // 2-bit saturating counter states
  localparam cnt_t CNT_SNT   = 2'b00;
  localparam cnt_t CNT_WNT   = 2'b01;
  localparam cnt_t CNT_WT    = 2'b10;
  localparam cnt_t CNT_ST    = 2'b11;
  localparam cnt_t CNT_RESET = CNT_WNT;

  // Counter-table indexing modes
  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

  // Move one step toward the outcome, holding at either end
  function automatic cnt_t sat_cnt_next(input cnt_t cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped branch target buffer with combinational lookup
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears valid bits only)
//   rd_idx, rd_tag        lookup index and tag
//   rd_hit, rd_target     lookup result; target forced to 0 on a miss
//   wr_en, wr_idx,        write port; a write always sets valid and replaces
//   wr_tag, wr_target     whatever entry currently lives at wr_idx
module bp_btb #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 30,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX-1:0]    rd_idx,
  input  logic [ADDR_W-IDX-1:0] rd_tag,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              wr_en,
  input  logic [IDX-1:0]    wr_idx,
  input  logic [ADDR_W-IDX-1:0] wr_tag,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int TAG_W = ADDR_W - IDX;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
    end
  end

  // Tag and target need no reset: a cleared valid bit masks them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = rd_hit ? target_q[rd_idx] : '0;

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare dynamic branch predictor with BTB and statistics
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stall                       pipeline stall; suppresses training
//   lookup_pc                   IF fetch word address
//   pred_hit/taken/target/ghr   same-cycle prediction and current global history
//   upd_valid/pc/ghr/taken/     resolved branch from ID
//   upd_target/upd_mispredict
//   branch_cnt, mispredict_cnt  wrapping statistics of applied updates
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int HIST_BITS = 4,
  parameter int MODE      = 0,
  parameter int ADDR_W    = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [ADDR_W-1:0]    lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [ADDR_W-1:0]    pred_target,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [ADDR_W-1:0]    upd_pc,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic [ADDR_W-1:0]    upd_target,
  input  logic                 upd_mispredict,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispredict_cnt
);

  localparam int IDX = $clog2(ENTRIES);

  cnt_t                 cnt_q [ENTRIES];
  cnt_t                 cnt_d [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispredict_cnt_q, mispredict_cnt_d;

  logic                 apply;
  logic [IDX-1:0]       lookup_cidx;
  logic [IDX-1:0]       upd_cidx;

  // Training uses the history captured at fetch so it lands on the entry
  // that produced the prediction, not the one the current GHR points to.
  function automatic logic [IDX-1:0] cnt_index(input logic [IDX-1:0] base,
                                               input logic [HIST_BITS-1:0] hist);
    if (MODE == BP_GSHARE) begin
      return base ^ IDX'(hist);
    end
    return base;
  endfunction

  // ID re-presents a stalled branch, so skipping it here trains it once
  assign apply       = upd_valid & ~stall;
  assign lookup_cidx = cnt_index(lookup_pc[IDX-1:0], ghr_q);
  assign upd_cidx    = cnt_index(upd_pc[IDX-1:0], upd_ghr);

  bp_btb #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .IDX     (IDX)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lookup_pc[IDX-1:0]),
    .rd_tag    (lookup_pc[ADDR_W-1:IDX]),
    .rd_hit    (pred_hit),
    .rd_target (pred_target),
    .wr_en     (apply & upd_taken),
    .wr_idx    (upd_pc[IDX-1:0]),
    .wr_tag    (upd_pc[ADDR_W-1:IDX]),
    .wr_target (upd_target)
  );

  always_comb begin
    cnt_d            = cnt_q;
    ghr_d            = ghr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (apply) begin
      cnt_d[upd_cidx] = sat_cnt_next(cnt_q[upd_cidx], upd_taken);
      ghr_d           = (ghr_q << 1) | HIST_BITS'(upd_taken);
      branch_cnt_d    = branch_cnt_q + 32'd1;
      if (upd_mispredict) begin
        mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q            <= '{default: CNT_RESET};
      ghr_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      cnt_q            <= cnt_d;
      ghr_q            <= ghr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign pred_taken     = pred_hit & cnt_q[lookup_cidx][1];
  assign pred_ghr       = ghr_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor in bimodal and gshare modes
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [29:0] lookup_pc;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_mispredict;

  logic [1:0]  o_hit;
  logic [1:0]  o_taken;
  logic [29:0] o_tgt [2];
  logic [3:0]  o_ghr [2];
  logic [31:0] o_bc  [2];
  logic [31:0] o_mc  [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: BTB and history are mode-independent, counters per mode
  bit          started = 0;
  bit          m_valid [16];
  logic [29:0] m_tag   [16];
  logic [29:0] m_tgt   [16];
  int          m_cnt   [2][16];
  int          m_ghr;
  logic [31:0] m_bc, m_mc;

  branch_predictor #(.ENTRIES(16), .HIST_BITS(4), .MODE(0), .ADDR_W(30)) u_bim (
    .clk(clk), .rst_n(rst_n), .stall(stall), .lookup_pc(lookup_pc),
    .pred_hit(o_hit[0]), .pred_taken(o_taken[0]), .pred_target(o_tgt[0]), .pred_ghr(o_ghr[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .branch_cnt(o_bc[0]), .mispredict_cnt(o_mc[0])
  );

  branch_predictor #(.ENTRIES(16), .HIST_BITS(4), .MODE(1), .ADDR_W(30)) u_gsh (
    .clk(clk), .rst_n(rst_n), .stall(stall), .lookup_pc(lookup_pc),
    .pred_hit(o_hit[1]), .pred_taken(o_taken[1]), .pred_target(o_tgt[1]), .pred_ghr(o_ghr[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .branch_cnt(o_bc[1]), .mispredict_cnt(o_mc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int ui, gi, k;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i]  = 0;
        m_cnt[0][i] = 1;
        m_cnt[1][i] = 1;
      end
      m_ghr   = 0;
      m_bc    = 0;
      m_mc    = 0;
      started = 1;
    end else if (upd_valid && !stall) begin
      ui = int'(upd_pc[3:0]);
      gi = ui ^ int'(upd_ghr);
      for (int m = 0; m < 2; m++) begin
        k = (m == 1) ? gi : ui;
        if (upd_taken) m_cnt[m][k] = (m_cnt[m][k] < 3) ? m_cnt[m][k] + 1 : 3;
        else           m_cnt[m][k] = (m_cnt[m][k] > 0) ? m_cnt[m][k] - 1 : 0;
      end
      if (upd_taken) begin
        m_valid[ui] = 1;
        m_tag[ui]   = upd_pc >> 4;
        m_tgt[ui]   = upd_target;
      end
      m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 15;
      m_bc  = m_bc + 32'd1;
      if (upd_mispredict) m_mc = m_mc + 32'd1;
    end
  end

  // Inputs change at negedge+1, so negedge+3 sees them settled before the update edge
  always @(negedge clk) begin : compare
    int idx, ci;
    logic eh;
    #3;
    if (started) begin
      idx = int'(lookup_pc[3:0]);
      eh  = m_valid[idx] && (m_tag[idx] == (lookup_pc >> 4));
      for (int m = 0; m < 2; m++) begin
        ci = (m == 1) ? (idx ^ m_ghr) : idx;
        check($sformatf("m%0d pred_hit", m),    32'(o_hit[m]),   32'(eh));
        check($sformatf("m%0d pred_taken", m),  32'(o_taken[m]), 32'(eh && (m_cnt[m][ci] >= 2)));
        check($sformatf("m%0d pred_target", m), 32'(o_tgt[m]),   eh ? 32'(m_tgt[idx]) : 32'd0);
        check($sformatf("m%0d pred_ghr", m),    32'(o_ghr[m]),   32'(m_ghr));
        check($sformatf("m%0d branch_cnt", m),  o_bc[m],         m_bc);
        check($sformatf("m%0d mispred_cnt", m), o_mc[m],         m_mc);
      end
    end
  end

  task automatic drive(input logic r, input logic uv, input logic st, input logic [29:0] upc,
                       input logic tk, input logic [29:0] tgt, input logic mis,
                       input logic [3:0] ug, input logic [29:0] lpc);
    @(negedge clk);
    #1;
    rst_n = r; upd_valid = uv; stall = st; upd_pc = upc; upd_taken = tk;
    upd_target = tgt; upd_mispredict = mis; upd_ghr = ug; lookup_pc = lpc;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 30'h40);
  endtask

  task automatic upd(input logic [29:0] pc, input logic tk, input logic [29:0] tgt,
                     input logic mis, input logic [3:0] ug);
    drive(1'b1, 1'b1, 1'b0, pc, tk, tgt, mis, ug, pc);
  endtask

  task automatic look(input logic [29:0] lpc);
    drive(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, lpc);
  endtask

  initial begin
    logic [3:0] exp_g [4];
    rst_n = 1'b0; stall = 1'b0; lookup_pc = 30'h40; upd_valid = 1'b0; upd_pc = '0;
    upd_ghr = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

    // Reset state
    do_reset();
    look(30'h40);
    check("rst hit", 32'(o_hit[0]), 32'd0);
    check("rst taken", 32'(o_taken[0]), 32'd0);
    check("rst target", 32'(o_tgt[0]), 32'd0);
    check("rst bcnt", o_bc[0], 32'd0);
    check("rst mcnt", o_mc[0], 32'd0);
    check("rst ghr", 32'(o_ghr[1]), 32'd0);

    // Training and saturation
    upd(30'h10, 1'b1, 30'h80, 1'b0, 4'h0);
    upd(30'h10, 1'b1, 30'h80, 1'b0, 4'h0);
    look(30'h10);
    check("train hit", 32'(o_hit[0]), 32'd1);
    check("train target", 32'(o_tgt[0]), 32'h80);
    check("train taken", 32'(o_taken[0]), 32'd1);
    upd(30'h10, 1'b1, 30'h80, 1'b0, 4'h0);
    upd(30'h10, 1'b0, 30'h0, 1'b0, 4'h0);
    look(30'h10);
    check("sat nt1 taken", 32'(o_taken[0]), 32'd1);
    upd(30'h10, 1'b0, 30'h0, 1'b0, 4'h0);
    look(30'h10);
    check("sat nt2 taken", 32'(o_taken[0]), 32'd0);
    check("sat nt2 hit", 32'(o_hit[0]), 32'd1);

    // Aliasing on index 0
    upd(30'h10, 1'b1, 30'h80, 1'b0, 4'h0);
    upd(30'h20, 1'b1, 30'h99, 1'b0, 4'h0);
    look(30'h10);
    check("alias old hit", 32'(o_hit[0]), 32'd0);
    look(30'h20);
    check("alias new hit", 32'(o_hit[0]), 32'd1);
    check("alias new target", 32'(o_tgt[0]), 32'h99);

    // Stall suppresses training
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b1, 30'h5, 1'b1, 30'h33, 1'b0, 4'h0, 30'h5);
    look(30'h5);
    check("stall bcnt", o_bc[0], 32'd0);
    check("stall hit", 32'(o_hit[0]), 32'd0);
    upd(30'h5, 1'b1, 30'h33, 1'b0, 4'h0);
    look(30'h5);
    check("unstall bcnt", o_bc[0], 32'd1);
    check("unstall hit", 32'(o_hit[0]), 32'd1);
    check("unstall target", 32'(o_tgt[0]), 32'h33);

    // Gshare history sequence T,N,T,T
    do_reset();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0101; exp_g[3] = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      upd(30'h1, (i != 1), 30'h11, 1'b0, 4'h0);
      look(30'h1);
      check($sformatf("gshare ghr %0d", i), 32'(o_ghr[1]), 32'(exp_g[i]));
    end

    // Gshare: pc 0x3 with history 0101 trains counter 6, seen via pc 0x5 with ghr 0011
    do_reset();
    upd(30'h5, 1'b1, 30'h50, 1'b0, 4'h8);
    upd(30'h3, 1'b1, 30'h44, 1'b0, 4'h5);
    look(30'h5);
    check("gshare ghr 3", 32'(o_ghr[1]), 32'h3);
    check("gshare idx6 taken", 32'(o_taken[1]), 32'd1);
    check("gshare idx6 target", 32'(o_tgt[1]), 32'h50);
    look(30'h3);
    check("gshare idx0 hit", 32'(o_hit[1]), 32'd1);
    check("gshare idx0 taken", 32'(o_taken[1]), 32'd0);

    // Same-cycle lookup and update
    do_reset();
    upd(30'h10, 1'b1, 30'h80, 1'b0, 4'h0);
    check("collide old hit", 32'(o_hit[0]), 32'd0);
    look(30'h10);
    check("collide new hit", 32'(o_hit[0]), 32'd1);
    check("collide new taken", 32'(o_taken[0]), 32'd1);
    upd(30'h10, 1'b0, 30'h0, 1'b1, 4'h0);
    check("collide2 old taken", 32'(o_taken[0]), 32'd1);
    look(30'h10);
    check("collide2 new taken", 32'(o_taken[0]), 32'd0);
    check("mispred cnt", o_mc[0], 32'd1);
    check("branch cnt", o_bc[0], 32'd2);

    // Randomized traffic over a small address range so entries alias and hit
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            30'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)),
            30'($urandom),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            30'($urandom_range(0, 63)));
    end
    look(30'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
